// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle control FSM for a single-issue datapath.
// Steps one instruction through FETCH, DECODE, OPERAND (direct mode only),
// EXECUTE and WRITEBACK. It owns the instruction register and drives the
// operand/ALU mux selects, the RAM handshake and the GPR/PC strobes.
//
// Optional feature: define SEQ_TIMEOUT_EN to enable a RAM wait watchdog that
// forces FAULT after MEM_TIMEOUT consecutive unanswered request cycles.
// With SEQ_TIMEOUT_EN undefined, requests wait indefinitely.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        cond_flag,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_addr_sel,
    output logic [31:0] ir,
    output logic [1:0]  mode,
    output logic        store,
    output logic        branch,
    output logic        alu_en,
    output logic        gpr_we,
    output logic        pc_inc,
    output logic        pc_load,
    output logic [2:0]  state,
    output logic        busy,
    output logic        fault
);

    // The encodings are visible on the state port, so they are fixed here.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_OPERAND   = 3'd3,
        S_EXECUTE   = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    // RAM address source select values.
    localparam logic [1:0] ADDR_PC    = 2'b00;
    localparam logic [1:0] ADDR_OPND  = 2'b01;
    localparam logic [1:0] ADDR_STORE = 2'b10;

    localparam logic [3:0] OPC_HALT    = 4'hF;
    localparam logic [1:0] MODE_DIRECT = 2'b01;

    // The watchdog threshold must fit the documented 1..255 range.
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("cpu_sequencer: MEM_TIMEOUT must be in 1..255");
    end

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        cond_q, cond_d;
    logic        fault_q, fault_d;

    // Instruction field views of the registered IR.
    logic [3:0]  ir_opcode;
    logic [1:0]  ir_mode;
    logic        ir_store;
    logic        ir_branch;
    logic        active;

    assign ir_opcode = ir_q[31:28];
    assign ir_mode   = ir_q[27:26];
    assign ir_store  = ir_q[25];
    assign ir_branch = ir_q[24];

    // DECODE..WRITEBACK are the states in which IR fields steer the datapath.
    assign active = (state_q == S_DECODE)  || (state_q == S_OPERAND) ||
                    (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);

`ifdef SEQ_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_hit;

    // The wait cycle that would bring the count up to MEM_TIMEOUT is the last one
    // allowed. An answer arriving in that cycle still wins over the fault.
    assign timeout_hit = mem_req && !mem_ready && (wait_q == WAIT_LAST);
`endif

    // Moore-style output decode from the registered state, IR and condition.
    // pc_inc is the one exception: it marks the cycle a fetch completes, so
    // the PC advances in step with the IR load.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = ADDR_PC;
        alu_en       = 1'b0;
        gpr_we       = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        mode         = 2'b00;
        store        = 1'b0;
        branch       = 1'b0;
        busy         = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_PC;
                pc_inc       = mem_ready;
                busy         = 1'b1;
            end
            S_DECODE: begin
                busy = 1'b1;
            end
            S_OPERAND: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_OPND;
                busy         = 1'b1;
            end
            S_EXECUTE: begin
                alu_en = 1'b1;
                busy   = 1'b1;
            end
            S_WRITEBACK: begin
                busy = 1'b1;
                if (ir_store) begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = ADDR_STORE;
                end else if (ir_branch) begin
                    pc_load = cond_q;
                end else begin
                    gpr_we = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Outside active states the mux selects fall back to GPR routing.
        if (active) begin
            mode   = ir_mode;
            store  = ir_store;
            branch = ir_branch;
        end
    end

    // Next-state, IR load, branch-condition latch and sticky fault.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cond_d  = cond_q;
        fault_d = fault_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ir_opcode == OPC_HALT) begin
                    state_d = S_HALT;
                end else if (ir_store && ir_branch) begin
                    state_d = S_FAULT;
                end else if (ir_mode == MODE_DIRECT) begin
                    state_d = S_OPERAND;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_OPERAND: begin
                if (mem_ready) begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                cond_d  = cond_flag;
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (!ir_store || mem_ready) begin
                    state_d = halt_req ? S_HALT : S_FETCH;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

`ifdef SEQ_TIMEOUT_EN
        if (timeout_hit) begin
            state_d = S_FAULT;
        end
`endif

        if (state_d == S_FAULT) begin
            fault_d = 1'b1;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Wait counter: counts unanswered request cycles, restarts on an answer,
    // whenever no request is outstanding, and on every state change.
    always_comb begin
        wait_d = wait_q;
        if (!mem_req || mem_ready || (state_d != state_q)) begin
            wait_d = '0;
        end else begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Wait counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    // Architectural state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cond_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cond_q  <= cond_d;
            fault_q <= fault_d;
        end
    end

    assign ir    = ir_q;
    assign state = state_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer. Each applyStimulus call advances one
// clock, drives the inputs for that cycle just after the rising edge, and
// returns at the falling edge so outputs of that cycle can be compared.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        cond_flag;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_addr_sel;
    logic [31:0] ir;
    logic [1:0]  mode;
    logic        store;
    logic        branch;
    logic        alu_en;
    logic        gpr_we;
    logic        pc_inc;
    logic        pc_load;
    logic [2:0]  state;
    logic        busy;
    logic        fault;

    int checks;
    int errors;

    cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .halt_req     (halt_req),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .cond_flag    (cond_flag),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir           (ir),
        .mode         (mode),
        .store        (store),
        .branch       (branch),
        .alu_en       (alu_en),
        .gpr_we       (gpr_we),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .state        (state),
        .busy         (busy),
        .fault        (fault)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic hr, input logic rdy,
                                 input logic cf, input logic [31:0] rd);
        @(posedge clk);
        #1;
        start     = st;
        halt_req  = hr;
        mem_ready = rdy;
        cond_flag = cf;
        mem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic idle_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        halt_req  = 1'b0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;
        cond_flag = 1'b0;

        // Reset state
        idle_cycle();
        idle_cycle();
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_ir", ir, 32'h0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_req", 32'(mem_req), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // mem_ready with no request is ignored
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0C000000);
        checkOutput("idle_state", 32'(state), 32'd0);
        checkOutput("idle_pcinc", 32'(pc_inc), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // ALU op, mode 11, to GPR: F D E W
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0C000000);
        checkOutput("alu_f_state", 32'(state), 32'd1);
        checkOutput("alu_f_req", 32'(mem_req), 32'd1);
        checkOutput("alu_f_sel", 32'(mem_addr_sel), 32'd0);
        checkOutput("alu_f_pcinc", 32'(pc_inc), 32'd1);
        checkOutput("alu_f_busy", 32'(busy), 32'd1);
        idle_cycle();
        checkOutput("alu_d_state", 32'(state), 32'd2);
        checkOutput("alu_d_ir", ir, 32'h0C000000);
        checkOutput("alu_d_mode", 32'(mode), 32'd3);
        checkOutput("alu_d_sb", {30'd0, store, branch}, 32'd0);
        checkOutput("alu_d_pcinc", 32'(pc_inc), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("alu_e_state", 32'(state), 32'd4);
        checkOutput("alu_e_aluen", 32'(alu_en), 32'd1);
        checkOutput("alu_e_mode", 32'(mode), 32'd3);
        idle_cycle();
        checkOutput("alu_w_state", 32'(state), 32'd5);
        checkOutput("alu_w_gprwe", 32'(gpr_we), 32'd1);
        checkOutput("alu_w_aluen", 32'(alu_en), 32'd0);
        checkOutput("alu_w_req", 32'(mem_req), 32'd0);
        checkOutput("alu_w_mode", 32'(mode), 32'd3);

        // Direct-mode load with two operand wait cycles: 7 cycles total
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h04000000);
        checkOutput("dir_f_state", 32'(state), 32'd1);
        idle_cycle();
        checkOutput("dir_d_state", 32'(state), 32'd2);
        checkOutput("dir_d_mode", 32'(mode), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, (i == 2), 1'b0, 32'h0);
            checkOutput("dir_o_state", 32'(state), 32'd3);
            checkOutput("dir_o_sel", 32'(mem_addr_sel), 32'd1);
            checkOutput("dir_o_req", 32'(mem_req), 32'd1);
        end
        idle_cycle();
        checkOutput("dir_e_state", 32'(state), 32'd4);
        idle_cycle();
        checkOutput("dir_w_state", 32'(state), 32'd5);
        checkOutput("dir_w_gprwe", 32'(gpr_we), 32'd1);

        // Store, zero waits
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h02000000);
        checkOutput("st_f_state", 32'(state), 32'd1);
        idle_cycle();
        checkOutput("st_d_store", 32'(store), 32'd1);
        idle_cycle();
        checkOutput("st_e_state", 32'(state), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("st_w_state", 32'(state), 32'd5);
        checkOutput("st_w_req", 32'(mem_req), 32'd1);
        checkOutput("st_w_we", 32'(mem_we), 32'd1);
        checkOutput("st_w_sel", 32'(mem_addr_sel), 32'd2);
        checkOutput("st_w_gprwe", 32'(gpr_we), 32'd0);

        // Branch taken
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h01000000);
        checkOutput("bt_f_state", 32'(state), 32'd1);
        idle_cycle();
        checkOutput("bt_d_branch", 32'(branch), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("bt_e_state", 32'(state), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("bt_w_state", 32'(state), 32'd5);
        checkOutput("bt_w_pcload", 32'(pc_load), 32'd1);
        checkOutput("bt_w_gprwe", 32'(gpr_we), 32'd0);

        // Branch not taken; cond_flag in WRITEBACK must not matter
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h01000000);
        idle_cycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("bn_e_state", 32'(state), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        checkOutput("bn_w_state", 32'(state), 32'd5);
        checkOutput("bn_w_pcload", 32'(pc_load), 32'd0);

        // HALT opcode with mode bits set: mux selects gated in HALT
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hFC000000);
        checkOutput("h_f_state", 32'(state), 32'd1);
        idle_cycle();
        checkOutput("h_d_mode", 32'(mode), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("h_state", 32'(state), 32'd6);
        checkOutput("h_mode", 32'(mode), 32'd0);
        checkOutput("h_busy", 32'(busy), 32'd0);

        // start resumes; halt_req sampled on completing WRITEBACK
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0C000000);
        checkOutput("hr_f_state", 32'(state), 32'd1);
        idle_cycle();
        idle_cycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("hr_w_state", 32'(state), 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("hr_state", 32'(state), 32'd6);

        // Illegal instruction -> FAULT, sticky
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h03000000);
        checkOutput("il_f_state", 32'(state), 32'd1);
        idle_cycle();
        checkOutput("il_d_state", 32'(state), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("il_state", 32'(state), 32'd7);
        checkOutput("il_fault", 32'(fault), 32'd1);
        checkOutput("il_sb", {30'd0, store, branch}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        end
        checkOutput("il_hold_state", 32'(state), 32'd7);
        checkOutput("il_hold_fault", 32'(fault), 32'd1);
        rst_n = 1'b0;
        idle_cycle();
        checkOutput("il_rst_state", 32'(state), 32'd0);
        checkOutput("il_rst_fault", 32'(fault), 32'd0);
        checkOutput("il_rst_ir", ir, 32'h0);
        rst_n = 1'b1;

        // Reset in the middle of a store wait
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h02000000);
        idle_cycle();
        idle_cycle();
        idle_cycle();
        checkOutput("rs_w_state", 32'(state), 32'd5);
        checkOutput("rs_w_we", 32'(mem_we), 32'd1);
        idle_cycle();
        checkOutput("rs_w2_req", 32'(mem_req), 32'd1);
        checkOutput("rs_w2_sel", 32'(mem_addr_sel), 32'd2);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rs_state", 32'(state), 32'd0);
        checkOutput("rs_req", 32'(mem_req), 32'd0);
        checkOutput("rs_we", 32'(mem_we), 32'd0);
        checkOutput("rs_sel", 32'(mem_addr_sel), 32'd0);
        rst_n = 1'b1;
        idle_cycle();

`ifdef SEQ_TIMEOUT_EN
        // Fetch never answered: FAULT after the 15th wait cycle
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) begin
            idle_cycle();
            checkOutput("to_wait_state", 32'(state), 32'd1);
        end
        idle_cycle();
        checkOutput("to_state", 32'(state), 32'd7);
        checkOutput("to_fault", 32'(fault), 32'd1);
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;

        // Answer arrives in the 15th wait cycle: normal progress
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 14; i++) begin
            idle_cycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0C000000);
        checkOutput("tl_last_state", 32'(state), 32'd1);
        idle_cycle();
        checkOutput("tl_state", 32'(state), 32'd2);
        checkOutput("tl_fault", 32'(fault), 32'd0);
        checkOutput("tl_ir", ir, 32'h0C000000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
